// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter: bridges the core's single-cycle-request data port onto a
// valid/ready request bus with a separate read-response channel. It stalls the
// core for the whole transaction, builds store lanes and extends load results,
// and aborts transactions that run longer than TIMEOUT_CYCLES.
module mem_bus_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessErr,
    output logic        TimeoutErr,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RESP,
        DONE,
        ERR
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [31:0]    r_adr;
    logic           r_we;
    logic [2:0]     r_funct3;
    logic [3:0]     r_be;
    logic [31:0]    r_wdata;
    logic [CW-1:0]  r_count;
    logic           r_errTimeout;
    logic [31:0]    r_readData;

    logic           w_illegal;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic           w_timeout;
    logic [15:0]    w_lane;
    logic [31:0]    w_loadData;

    // Decode the incoming request: legality, byte enables and replicated store data.
    always_comb begin
        w_illegal = 1'b0;
        w_be      = 4'b1111;
        w_wdata   = WriteData;
        case (funct3)
            3'b000, 3'b100: begin
                w_wdata = {4{WriteData[7:0]}};
                if (MemWrite) w_be = 4'b0001 << Adr[1:0];
            end
            3'b001, 3'b101: begin
                w_wdata = {2{WriteData[15:0]}};
                if (MemWrite) w_be = Adr[1] ? 4'b1100 : 4'b0011;
                if (Adr[0]) w_illegal = 1'b1;
            end
            3'b010: begin
                if (Adr[1:0] != 2'b00) w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if (MemWrite && funct3[2]) w_illegal = 1'b1;
    end

    // The transaction has used its last allowed cycle in ADDR/RESP.
    assign w_timeout = (r_count == LAST_COUNT);

    // Pick the addressed byte/halfword out of the response word; a halfword is
    // always aligned, so shifting by the byte offset serves both widths.
    assign w_lane = 16'(bus_rdata >> {r_adr[1:0], 3'b000});

    // Extend the selected lane according to the latched access width and sign.
    always_comb begin
        w_loadData = bus_rdata;
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_loadData = {{16{w_lane[15]}}, w_lane};
            3'b100:  w_loadData = {24'b0, w_lane[7:0]};
            3'b101:  w_loadData = {16'b0, w_lane};
            default: w_loadData = bus_rdata;
        endcase
    end

    // Next-state logic; a handshake in the final allowed cycle still wins over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (MemReq) w_next = w_illegal ? ERR : ADDR;
            end
            ADDR: begin
                if (bus_ready)      w_next = r_we ? DONE : RESP;
                else if (w_timeout) w_next = ERR;
            end
            RESP: begin
                if (bus_rvalid)     w_next = DONE;
                else if (w_timeout) w_next = ERR;
            end
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register plus request latching, timeout counting and load capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_adr        <= '0;
            r_we         <= 1'b0;
            r_funct3     <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_count      <= '0;
            r_errTimeout <= 1'b0;
            r_readData   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (MemReq) begin
                        r_adr        <= Adr;
                        r_we         <= MemWrite;
                        r_funct3     <= funct3;
                        r_be         <= w_be;
                        r_wdata      <= w_wdata;
                        r_count      <= '0;
                        r_errTimeout <= 1'b0;
                    end
                end
                ADDR, RESP: begin
                    r_count <= r_count + CW'(1);
                    if (w_next == ERR) r_errTimeout <= 1'b1;
                    if ((r_state == RESP) && bus_rvalid) r_readData <= w_loadData;
                end
                default: begin
                end
            endcase
        end
    end

    // Status toward the core and the bus; reset masks the request and error strobes at once.
    assign Stall      = MemReq && (r_state != DONE) && (r_state != ERR);
    assign bus_valid  = (r_state == ADDR) && !reset;
    assign AccessErr  = (r_state == ERR) && !r_errTimeout && !reset;
    assign TimeoutErr = (r_state == ERR) && r_errTimeout && !reset;
    assign bus_we     = r_we;
    assign bus_addr   = {r_adr[31:2], 2'b00};
    assign bus_wdata  = r_wdata;
    assign bus_be     = r_be;
    assign ReadData   = r_readData;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// tb_mem_bus_adapter: directed and random transactions against mem_bus_adapter,
// checked against a transaction-level model of lanes, extension and timeouts.
module tb_mem_bus_adapter;

    localparam int TMO = 16;

    logic        clk;
    logic        reset;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [2:0]  funct3;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    logic [31:0] ReadData;
    logic        Stall;
    logic        AccessErr;
    logic        TimeoutErr;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;

    logic [31:0] ReadData4;
    logic        Stall4;
    logic        AccessErr4;
    logic        TimeoutErr4;
    logic        bus_valid4;
    logic        bus_we4;
    logic [31:0] bus_addr4;
    logic [31:0] bus_wdata4;
    logic [3:0]  bus_be4;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelRd = 32'h0;

    mem_bus_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
        .Adr(Adr), .WriteData(WriteData), .funct3(funct3),
        .ReadData(ReadData), .Stall(Stall), .AccessErr(AccessErr),
        .TimeoutErr(TimeoutErr), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    mem_bus_adapter #(.TIMEOUT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
        .Adr(Adr), .WriteData(WriteData), .funct3(funct3),
        .ReadData(ReadData4), .Stall(Stall4), .AccessErr(AccessErr4),
        .TimeoutErr(TimeoutErr4), .bus_valid(bus_valid4), .bus_ready(bus_ready),
        .bus_we(bus_we4), .bus_addr(bus_addr4), .bus_wdata(bus_wdata4),
        .bus_be(bus_be4), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with the model's value and count the outcome.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit isLegal(input logic we, input logic [31:0] adr, input logic [2:0] f3);
        int a;
        a = int'(adr % 4);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b0;
        if (we && f3 >= 4) return 1'b0;
        if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b0;
        if (f3 == 2 && a != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] expBe(input logic we, input logic [31:0] adr, input logic [2:0] f3);
        int a;
        a = int'(adr % 4);
        if (!we) return 4'hF;
        if (f3 == 0) return 4'(1 << a);
        if (f3 == 1) return (a >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] expWdata(input logic [31:0] wd, input logic [2:0] f3);
        if (f3 == 0) return (wd & 32'hFF) * 32'h01010101;
        if (f3 == 1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] adr, input logic [31:0] rdata);
        logic [31:0] sh, b, h;
        sh = rdata >> (8 * (adr % 4));
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // Run one core request through the adapter while acting as the bus slave,
    // checking every cycle from the request until one idle cycle afterwards.
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                                 input logic [2:0] f3, input int rdyDly, input int rvDly,
                                 input logic [31:0] rdata, input bit junk, input bit dropEarly);
        bit          legal, tmo, memNow, expValid;
        int          total, endC;
        logic [3:0]  eBe;
        logic [31:0] eWd, eLd;
        legal = isLegal(we, adr, f3);
        total = (rdyDly + 1) + (we ? 0 : rvDly + 1);
        tmo   = legal && (total > TMO);
        endC  = !legal ? 1 : (tmo ? TMO + 1 : total + 1);
        eBe   = expBe(we, adr, f3);
        eWd   = expWdata(wd, f3);
        eLd   = expLoad(f3, adr, rdata);
        for (int c = 0; c <= endC; c++) begin
            @(negedge clk);
            memNow = !(dropEarly && c >= 2);
            MemReq = memNow;
            if (c == 0) begin
                MemWrite = we; Adr = adr; WriteData = wd; funct3 = f3;
            end else begin
                MemWrite = 1'($urandom); Adr = $urandom; WriteData = $urandom; funct3 = 3'($urandom);
            end
            bus_ready = legal && (c >= 1 + rdyDly);
            if (legal && !we && c == 2 + rdyDly + rvDly) begin
                bus_rvalid = 1'b1; bus_rdata = rdata;
            end else if (junk && c <= 1 + rdyDly) begin
                bus_rvalid = 1'b1; bus_rdata = ~rdata;
            end else begin
                bus_rvalid = 1'b0; bus_rdata = $urandom;
            end
            #1;
            expValid = legal && c >= 1 && c < endC && c <= 1 + rdyDly;
            checkOutput($sformatf("stall c%0d", c), Stall, memNow && c != endC);
            checkOutput($sformatf("bus_valid c%0d", c), bus_valid, expValid);
            checkOutput($sformatf("access_err c%0d", c), AccessErr, !legal && c == endC);
            checkOutput($sformatf("timeout_err c%0d", c), TimeoutErr, tmo && c == endC);
            if (expValid) begin
                checkOutput("bus_addr", bus_addr, adr & 32'hFFFFFFFC);
                checkOutput("bus_we", bus_we, we);
                checkOutput("bus_be", bus_be, eBe);
                if (we) checkOutput("bus_wdata", bus_wdata, eWd);
            end
            if (c == endC) begin
                if (legal && !we && !tmo) modelRd = eLd;
                checkOutput("read_data", ReadData, modelRd);
            end
        end
        @(negedge clk);
        MemReq = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1;
        checkOutput("idle bus_valid", bus_valid, 1'b0);
        checkOutput("idle stall", Stall, 1'b0);
        checkOutput("idle err", {AccessErr, TimeoutErr}, 2'b00);
        checkOutput("idle read_data", ReadData, modelRd);
    endtask

    initial begin
        logic [2:0]  legalF3 [5];
        logic [2:0]  f3;
        logic [31:0] adr;
        legalF3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Adr = '0; WriteData = '0;
        funct3 = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

        // Reset: strobes low during reset and afterwards, ReadData cleared.
        repeat (2) begin
            @(negedge clk); #1;
            checkOutput("reset bus_valid", bus_valid, 1'b0);
            checkOutput("reset err", {AccessErr, TimeoutErr}, 2'b00);
        end
        @(negedge clk); reset = 1'b0; #1;
        checkOutput("post-reset read_data", ReadData, 32'h0);
        checkOutput("post-reset bus_valid", bus_valid, 1'b0);
        checkOutput("post-reset err", {AccessErr, TimeoutErr}, 2'b00);

        // Directed transactions from the worked examples.
        applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h203, 32'h0, 3'b000, 3, 0, 32'h80112233, 1'b1, 1'b0);
        checkOutput("lb value", ReadData, 32'hFFFFFF80);
        applyStimulus(1'b0, 32'h203, 32'h0, 3'b100, 3, 0, 32'h80112233, 1'b0, 1'b0);
        checkOutput("lbu value", ReadData, 32'h00000080);
        applyStimulus(1'b1, 32'h42, 32'h1234ABCD, 3'b001, 0, 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h41, 32'h0, 3'b010, 0, 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b011, 0, 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h55, 3'b100, 0, 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h6, 32'h0, 3'b001, 1, 2, 32'h9ABC7FFF, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h20, 32'h0, 3'b010, 2, 30, 32'h11111111, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h24, 32'h77, 3'b010, 40, 0, 32'h0, 1'b1, 1'b0);

        // Reset while waiting in RESP abandons the load; a late response is ignored.
        @(negedge clk); MemReq = 1'b1; MemWrite = 1'b0; Adr = 32'h0; funct3 = 3'b010;
        @(negedge clk); bus_ready = 1'b1;
        @(negedge clk); bus_ready = 1'b0; reset = 1'b1; #1;
        checkOutput("rst-resp bus_valid", bus_valid, 1'b0);
        checkOutput("rst-resp err", {AccessErr, TimeoutErr}, 2'b00);
        @(negedge clk); reset = 1'b0; MemReq = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678; #1;
        modelRd = 32'h0;
        checkOutput("rst-resp read_data", ReadData, modelRd);
        checkOutput("rst-resp after bus_valid", bus_valid, 1'b0);
        checkOutput("rst-resp stall", Stall, 1'b0);
        @(negedge clk); bus_rvalid = 1'b0; #1;
        checkOutput("late rvalid ignored", ReadData, modelRd);

        // Reset while presenting a request in ADDR drops bus_valid.
        @(negedge clk); MemReq = 1'b1; MemWrite = 1'b1; Adr = 32'h30; funct3 = 3'b010;
        @(negedge clk); #1;
        checkOutput("addr bus_valid", bus_valid, 1'b1);
        @(negedge clk); reset = 1'b1; #1;
        checkOutput("rst-addr bus_valid", bus_valid, 1'b0);
        @(negedge clk); reset = 1'b0; MemReq = 1'b0; #1;
        checkOutput("rst-addr after bus_valid", bus_valid, 1'b0);

        // Four-cycle timeout instance with bus_ready stuck low.
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            MemReq = (c < 6); MemWrite = 1'b1; Adr = 32'h10; WriteData = 32'hCAFE; funct3 = 3'b010;
            bus_ready = 1'b0; bus_rvalid = 1'b0;
            #1;
            checkOutput($sformatf("t4 bus_valid c%0d", c), bus_valid4, (c >= 1 && c <= 4));
            checkOutput($sformatf("t4 timeout_err c%0d", c), TimeoutErr4, (c == 5));
            checkOutput($sformatf("t4 access_err c%0d", c), AccessErr4, 1'b0);
            checkOutput($sformatf("t4 stall c%0d", c), Stall4, (c < 5));
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        checkOutput("t4 after reset read_data", ReadData, modelRd);

        // Random transactions, including illegal ones, timeouts and early MemReq drop.
        for (int i = 0; i < 60; i++) begin
            f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legalF3[$urandom_range(0, 4)];
            adr = $urandom;
            if ($urandom_range(0, 1) == 1) adr = adr & 32'hFFFFFFFC;
            applyStimulus(1'($urandom_range(0, 1)), adr, $urandom, f3,
                          $urandom_range(0, 9), $urandom_range(0, 9), $urandom,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
